// File: rtl/regfile_pkg.sv
// Shared widths, reset-pattern helper and slot field bundle for the register-file stage.
package regfile_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int OPC_W_DEF  = 4;
   localparam int DMA_W_DEF  = 4;
   localparam int DEPTH_DEF  = 8;
   localparam int AW_DEF     = $clog2(DEPTH_DEF);

   typedef struct packed {
      logic [AW_DEF-1:0]    opa;
      logic [AW_DEF-1:0]    opb;
      logic [AW_DEF-1:0]    dest;
      logic [OPC_W_DEF-1:0] opcode;
      logic [DMA_W_DEF-1:0] dmaddr;
   } rs_fields_t;

   // Register i starts at i*step, the top register at all ones; callers truncate to DATA_W.
   function automatic logic [63:0] reset_value(input int i, input int depth,
                                               input int data_w, input logic [63:0] step);
      logic [63:0] mask;
      mask = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
      if (i == depth - 1) return mask;
      return (64'(i) * step) & mask;
   endfunction

endpackage

// File: rtl/regfile_stage_if.sv
// Decode-side, writeback and execute-side signals of the register-file stage.
interface regfile_stage_if #(
   parameter int AW     = 3,
   parameter int DATA_W = 8,
   parameter int OPC_W  = 4,
   parameter int DMA_W  = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [AW-1:0]     in_opa;
   logic [AW-1:0]     in_opb;
   logic [AW-1:0]     in_dest;
   logic [OPC_W-1:0]  in_opcode;
   logic [DMA_W-1:0]  in_dmaddr;
   logic              flush;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_operand_a;
   logic [DATA_W-1:0] out_operand_b;
   logic [AW-1:0]     out_opa;
   logic [AW-1:0]     out_opb;
   logic [AW-1:0]     out_dest;
   logic [OPC_W-1:0]  out_opcode;
   logic [DMA_W-1:0]  out_dmaddr;

   modport master (
      output in_valid, in_opa, in_opb, in_dest, in_opcode, in_dmaddr,
             flush, wr_en, wr_addr, wr_data, out_ready,
      input  in_ready, out_valid, out_operand_a, out_operand_b,
             out_opa, out_opb, out_dest, out_opcode, out_dmaddr
   );

   modport slave (
      input  in_valid, in_opa, in_opb, in_dest, in_opcode, in_dmaddr,
             flush, wr_en, wr_addr, wr_data, out_ready,
      output in_ready, out_valid, out_operand_a, out_operand_b,
             out_opa, out_opb, out_dest, out_opcode, out_dmaddr
   );
endinterface

// File: rtl/regfile_array.sv
// Register storage with two combinational read ports; same-cycle write forwarding
// on the read ports is enabled by defining REGFILE_FORWARD_EN.
module regfile_array
   import regfile_pkg::*;
#(
   parameter int                DATA_W     = DATA_W_DEF,
   parameter int                DEPTH      = DEPTH_DEF,
   parameter logic [DATA_W-1:0] RESET_STEP = 8'h22,
   parameter bit                ZERO_REG   = 1'b0,
   localparam int               AW         = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_wr_en,
   input  logic [AW-1:0]     i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [AW-1:0]     i_rd_addr_a,
   input  logic [AW-1:0]     i_rd_addr_b,
   output logic [DATA_W-1:0] o_rd_data_a,
   output logic [DATA_W-1:0] o_rd_data_b
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_wr_ok;
   logic [DATA_W-1:0] w_rd_data_a;
   logic [DATA_W-1:0] w_rd_data_b;

   assign w_wr_ok = i_wr_en && !(ZERO_REG && i_wr_addr == '0);

   // NOTE: the array is flops, not a RAM macro, so every entry is async-reset to its pattern.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= DATA_W'(reset_value(i, DEPTH, DATA_W, 64'(RESET_STEP)));
      end else if (w_wr_ok) begin
         // NOTE: non-blocking so every reader of r_mem this edge sees the pre-write value.
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // NOTE: defaults first on every path keep this purely combinational (no latch).
   always_comb begin
      w_rd_data_a = r_mem[i_rd_addr_a];
      w_rd_data_b = r_mem[i_rd_addr_b];
`ifdef REGFILE_FORWARD_EN
      if (w_wr_ok && i_wr_addr == i_rd_addr_a) w_rd_data_a = i_wr_data;
      if (w_wr_ok && i_wr_addr == i_rd_addr_b) w_rd_data_b = i_wr_data;
`endif
      if (ZERO_REG && i_rd_addr_a == '0) w_rd_data_a = '0;
      if (ZERO_REG && i_rd_addr_b == '0) w_rd_data_b = '0;
   end

   assign o_rd_data_a = w_rd_data_a;
   assign o_rd_data_b = w_rd_data_b;

endmodule

// File: rtl/regfile_stage.sv
// Register file fused with the decode-to-execute slot (valid/ready, stall, flush).
// Define REGFILE_FORWARD_EN to forward writeback data into accepted and stalled operands.
module regfile_stage
   import regfile_pkg::*;
#(
   parameter int                DATA_W     = DATA_W_DEF,
   parameter int                DEPTH      = DEPTH_DEF,
   parameter int                OPC_W      = OPC_W_DEF,
   parameter int                DMA_W      = DMA_W_DEF,
   parameter logic [DATA_W-1:0] RESET_STEP = 8'h22,
   parameter bit                ZERO_REG   = 1'b0,
   localparam int               AW         = $clog2(DEPTH)
) (
   input logic            clk,
   input logic            reset,
   regfile_stage_if.slave bus
);

   logic              w_accept;
   logic [DATA_W-1:0] w_rd_a;
   logic [DATA_W-1:0] w_rd_b;

   logic              r_valid;
   logic [DATA_W-1:0] r_op_a;
   logic [DATA_W-1:0] r_op_b;
   logic [AW-1:0]     r_opa;
   logic [AW-1:0]     r_opb;
   logic [AW-1:0]     r_dest;
   logic [OPC_W-1:0]  r_opcode;
   logic [DMA_W-1:0]  r_dmaddr;

   regfile_array #(
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .RESET_STEP (RESET_STEP),
      .ZERO_REG   (ZERO_REG)
   ) u_array (
      .clk         (clk),
      .reset       (reset),
      .i_wr_en     (bus.wr_en),
      .i_wr_addr   (bus.wr_addr),
      .i_wr_data   (bus.wr_data),
      .i_rd_addr_a (bus.in_opa),
      .i_rd_addr_b (bus.in_opb),
      .o_rd_data_a (w_rd_a),
      .o_rd_data_b (w_rd_b)
   );

   assign bus.in_ready = !bus.flush && (!r_valid || bus.out_ready);
   assign w_accept     = bus.in_valid && bus.in_ready;

`ifdef REGFILE_FORWARD_EN
   logic w_fwd_a;
   logic w_fwd_b;
   assign w_fwd_a = bus.wr_en && bus.wr_addr == r_opa && !(ZERO_REG && r_opa == '0);
   assign w_fwd_b = bus.wr_en && bus.wr_addr == r_opb && !(ZERO_REG && r_opb == '0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid  <= 1'b0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_dest   <= '0;
         r_opcode <= '0;
         r_dmaddr <= '0;
      end else if (w_accept) begin
         r_valid  <= 1'b1;
         r_op_a   <= w_rd_a;
         r_op_b   <= w_rd_b;
         r_opa    <= bus.in_opa;
         r_opb    <= bus.in_opb;
         r_dest   <= bus.in_dest;
         r_opcode <= bus.in_opcode;
         r_dmaddr <= bus.in_dmaddr;
      end else if (bus.flush || bus.out_ready) begin
         // Flush, or drain with nothing accepted; clearing an empty slot is harmless.
         r_valid <= 1'b0;
`ifdef REGFILE_FORWARD_EN
      end else if (r_valid) begin
         if (w_fwd_a) r_op_a <= bus.wr_data;
         if (w_fwd_b) r_op_b <= bus.wr_data;
`endif
      end
   end

   assign bus.out_valid     = r_valid;
   assign bus.out_operand_a = r_op_a;
   assign bus.out_operand_b = r_op_b;
   assign bus.out_opa       = r_opa;
   assign bus.out_opb       = r_opb;
   assign bus.out_dest      = r_dest;
   assign bus.out_opcode    = r_opcode;
   assign bus.out_dmaddr    = r_dmaddr;

endmodule

// File: tb/tb_regfile_stage.sv
// Bench for regfile_stage: one ZERO_REG=0 and one ZERO_REG=1 instance share stimulus
// and are compared every cycle against an array/slot model; follows REGFILE_FORWARD_EN.
module tb_regfile_stage;
   import regfile_pkg::*;

`ifdef REGFILE_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   regfile_stage_if #(.AW(3), .DATA_W(8), .OPC_W(4), .DMA_W(4)) bus0 ();
   regfile_stage_if #(.AW(3), .DATA_W(8), .OPC_W(4), .DMA_W(4)) bus1 ();

   assign bus1.in_valid  = bus0.in_valid;
   assign bus1.in_opa    = bus0.in_opa;
   assign bus1.in_opb    = bus0.in_opb;
   assign bus1.in_dest   = bus0.in_dest;
   assign bus1.in_opcode = bus0.in_opcode;
   assign bus1.in_dmaddr = bus0.in_dmaddr;
   assign bus1.flush     = bus0.flush;
   assign bus1.wr_en     = bus0.wr_en;
   assign bus1.wr_addr   = bus0.wr_addr;
   assign bus1.wr_data   = bus0.wr_data;
   assign bus1.out_ready = bus0.out_ready;

   regfile_stage #(.DEPTH(8), .ZERO_REG(1'b0)) u_dut (
      .clk(clk), .reset(reset), .bus(bus0));
   regfile_stage #(.DEPTH(8), .ZERO_REG(1'b1)) u_dut_zero (
      .clk(clk), .reset(reset), .bus(bus1));

   // Model: index k=1 is the instance with register 0 hardwired to zero.
   logic [7:0] m_mem   [2][8];
   logic       m_valid [2];
   logic [7:0] m_a     [2];
   logic [7:0] m_b     [2];
   rs_fields_t m_f     [2];
   logic       m_in_ready [2];
   logic       m_acc      [2];
   logic [7:0] m_rd_a     [2];
   logic [7:0] m_rd_b     [2];

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         m_in_ready[k] = !bus0.flush && (!m_valid[k] || bus0.out_ready);
         m_acc[k]      = bus0.in_valid && m_in_ready[k];
         m_rd_a[k]     = (FWD && bus0.wr_en && bus0.wr_addr == bus0.in_opa)
                         ? bus0.wr_data : m_mem[k][bus0.in_opa];
         m_rd_b[k]     = (FWD && bus0.wr_en && bus0.wr_addr == bus0.in_opb)
                         ? bus0.wr_data : m_mem[k][bus0.in_opb];
         if (k == 1 && bus0.in_opa == 3'd0) m_rd_a[k] = 8'h00;
         if (k == 1 && bus0.in_opb == 3'd0) m_rd_b[k] = 8'h00;
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++)
               m_mem[k][i] <= (i == 7) ? 8'hff : 8'(i * 8'h22);
            m_valid[k] <= 1'b0;
            m_a[k]     <= 8'h00;
            m_b[k]     <= 8'h00;
            m_f[k]     <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_acc[k]) begin
               m_valid[k] <= 1'b1;
               m_a[k]     <= m_rd_a[k];
               m_b[k]     <= m_rd_b[k];
               m_f[k]     <= '{opa: bus0.in_opa, opb: bus0.in_opb, dest: bus0.in_dest,
                               opcode: bus0.in_opcode, dmaddr: bus0.in_dmaddr};
            end else if (bus0.flush) begin
               m_valid[k] <= 1'b0;
            end else if (m_valid[k] && bus0.out_ready) begin
               m_valid[k] <= 1'b0;
            end else if (m_valid[k] && FWD && bus0.wr_en) begin
               if (bus0.wr_addr == m_f[k].opa && !(k == 1 && m_f[k].opa == 3'd0))
                  m_a[k] <= bus0.wr_data;
               if (bus0.wr_addr == m_f[k].opb && !(k == 1 && m_f[k].opb == 3'd0))
                  m_b[k] <= bus0.wr_data;
            end
            if (bus0.wr_en && !(k == 1 && bus0.wr_addr == 3'd0))
               m_mem[k][bus0.wr_addr] <= bus0.wr_data;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic cmp(input int k, input logic ov, input logic ir, input logic [7:0] a,
                      input logic [7:0] b, input logic [2:0] opa, input logic [2:0] opb,
                      input logic [2:0] dest, input logic [3:0] opc, input logic [3:0] dma);
      check($sformatf("i%0d out_valid", k), 32'(ov), 32'(m_valid[k]));
      check($sformatf("i%0d in_ready", k), 32'(ir), 32'(m_in_ready[k]));
      check($sformatf("i%0d operand_a", k), 32'(a), 32'(m_a[k]));
      check($sformatf("i%0d operand_b", k), 32'(b), 32'(m_b[k]));
      check($sformatf("i%0d out_opa", k), 32'(opa), 32'(m_f[k].opa));
      check($sformatf("i%0d out_opb", k), 32'(opb), 32'(m_f[k].opb));
      check($sformatf("i%0d out_dest", k), 32'(dest), 32'(m_f[k].dest));
      check($sformatf("i%0d out_opcode", k), 32'(opc), 32'(m_f[k].opcode));
      check($sformatf("i%0d out_dmaddr", k), 32'(dma), 32'(m_f[k].dmaddr));
   endtask

   always @(negedge clk) begin
      cmp(0, bus0.out_valid, bus0.in_ready, bus0.out_operand_a, bus0.out_operand_b,
          bus0.out_opa, bus0.out_opb, bus0.out_dest, bus0.out_opcode, bus0.out_dmaddr);
      cmp(1, bus1.out_valid, bus1.in_ready, bus1.out_operand_a, bus1.out_operand_b,
          bus1.out_opa, bus1.out_opb, bus1.out_dest, bus1.out_opcode, bus1.out_dmaddr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] a, input logic [2:0] b);
      bus0.in_valid  = v;
      bus0.in_opa    = a;
      bus0.in_opb    = b;
      bus0.in_dest   = a ^ b;
      bus0.in_opcode = {1'b1, a};
      bus0.in_dmaddr = {b, 1'b0};
   endtask

   task automatic wr(input logic en, input logic [2:0] addr, input logic [7:0] data);
      bus0.wr_en   = en;
      bus0.wr_addr = addr;
      bus0.wr_data = data;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      drive(1'b0, 3'd0, 3'd0);
      wr(1'b0, 3'd0, 8'h00);
      bus0.flush     = 1'b0;
      bus0.out_ready = 1'b1;
      #2 reset = 1'b1;
      tick();
      tick();
      check("rst out_valid", 32'(bus0.out_valid), 32'd0);
      check("rst operand_b", 32'(bus0.out_operand_b), 32'd0);
      check("rst out_opcode", 32'(bus0.out_opcode), 32'd0);
      check("rst in_ready", 32'(bus0.in_ready), 32'd1);
      reset = 1'b0;

      // Reset pattern: reg1 = 0x22, reg7 = all ones; one-cycle latency.
      drive(1'b1, 3'd1, 3'd7);
      bus0.in_dest   = 3'd2;
      bus0.in_opcode = 4'd5;
      bus0.in_dmaddr = 4'd9;
      tick();
      check("accept valid", 32'(bus0.out_valid), 32'd1);
      check("accept a", 32'(bus0.out_operand_a), 32'h22);
      check("accept b", 32'(bus0.out_operand_b), 32'hff);
      check("accept dest", 32'(bus0.out_dest), 32'd2);
      check("accept opcode", 32'(bus0.out_opcode), 32'd5);
      check("accept dmaddr", 32'(bus0.out_dmaddr), 32'd9);
      drive(1'b0, 3'd1, 3'd7);
      tick();
      check("drain valid", 32'(bus0.out_valid), 32'd0);
      check("drain holds a", 32'(bus0.out_operand_a), 32'h22);

      // Same-cycle write and accept of reg 3.
      drive(1'b1, 3'd3, 3'd4);
      wr(1'b1, 3'd3, 8'h5a);
      tick();
      check("hazard a", 32'(bus0.out_operand_a), FWD ? 32'h5a : 32'h66);
      check("hazard b", 32'(bus0.out_operand_b), 32'h88);
      wr(1'b0, 3'd0, 8'h00);
      tick();
      check("after write a", 32'(bus0.out_operand_a), 32'h5a);

      // Three-cycle stall with a write to the held opb index.
      drive(1'b1, 3'd1, 3'd2);
      tick();
      check("pre-stall b", 32'(bus0.out_operand_b), 32'h44);
      bus0.out_ready = 1'b0;
      drive(1'b1, 3'd6, 3'd6);
      wr(1'b1, 3'd2, 8'h11);
      #1;
      check("stall in_ready", 32'(bus0.in_ready), 32'd0);
      tick();
      wr(1'b0, 3'd0, 8'h00);
      tick();
      tick();
      check("stall valid", 32'(bus0.out_valid), 32'd1);
      check("stall opa", 32'(bus0.out_opa), 32'd1);
      check("stall a", 32'(bus0.out_operand_a), 32'h22);
      check("stall b", 32'(bus0.out_operand_b), FWD ? 32'h11 : 32'h44);
      check("stall in_ready end", 32'(bus0.in_ready), 32'd0);
      bus0.out_ready = 1'b1;
      drive(1'b1, 3'd6, 3'd2);
      tick();
      check("post-stall a", 32'(bus0.out_operand_a), 32'hcc);
      check("post-stall b", 32'(bus0.out_operand_b), 32'h11);

      // Flush beats a pending accept; the concurrent write still lands.
      bus0.out_ready = 1'b0;
      drive(1'b1, 3'd5, 3'd5);
      bus0.flush = 1'b1;
      wr(1'b1, 3'd2, 8'h77);
      #1;
      check("flush in_ready", 32'(bus0.in_ready), 32'd0);
      tick();
      check("flush valid", 32'(bus0.out_valid), 32'd0);
      check("flush no capture", 32'(bus0.out_opa), 32'd6);
      bus0.flush     = 1'b0;
      bus0.out_ready = 1'b1;
      wr(1'b0, 3'd0, 8'h00);
      drive(1'b1, 3'd2, 3'd5);
      tick();
      check("flush write a", 32'(bus0.out_operand_a), 32'h77);
      check("flush write b", 32'(bus0.out_operand_b), 32'haa);

      // Register 0: writable on instance 0, hardwired on instance 1.
      drive(1'b1, 3'd0, 3'd0);
      wr(1'b1, 3'd0, 8'hab);
      tick();
      check("zero fwd i0", 32'(bus0.out_operand_a), FWD ? 32'hab : 32'h00);
      check("zero fwd i1", 32'(bus1.out_operand_a), 32'h00);
      wr(1'b0, 3'd0, 8'h00);
      tick();
      check("zero read i0", 32'(bus0.out_operand_a), 32'hab);
      check("zero read i1", 32'(bus1.out_operand_a), 32'h00);
      bus0.out_ready = 1'b0;
      wr(1'b1, 3'd0, 8'hcd);
      tick();
      check("zero hold i0", 32'(bus0.out_operand_b), FWD ? 32'hcd : 32'hab);
      check("zero hold i1", 32'(bus1.out_operand_b), 32'h00);

      // Reset while stalled: slot drops at once, array returns to its pattern.
      wr(1'b1, 3'd5, 8'h13);
      drive(1'b1, 3'd4, 3'd4);
      tick();
      wr(1'b0, 3'd0, 8'h00);
      reset = 1'b1;
      #1;
      check("async rst valid i0", 32'(bus0.out_valid), 32'd0);
      check("async rst valid i1", 32'(bus1.out_valid), 32'd0);
      check("async rst a", 32'(bus0.out_operand_a), 32'd0);
      tick();
      reset = 1'b0;
      bus0.out_ready = 1'b1;
      drive(1'b1, 3'd5, 3'd7);
      tick();
      check("post rst reg5", 32'(bus0.out_operand_a), 32'haa);
      check("post rst reg7", 32'(bus0.out_operand_b), 32'hff);

      // Back-to-back accepts at full rate.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 3'(i), 3'(7 - i));
         tick();
      end
      check("stream a", 32'(bus0.out_operand_a), 32'hff);
      check("stream b", 32'(bus0.out_operand_b), 32'h00);
      check("stream valid", 32'(bus0.out_valid), 32'd1);
      drive(1'b0, 3'd0, 3'd0);
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
